// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and memory-load writeback, with a per-register RAW scoreboard.
// Optional: define WB_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module regfile_wb_arbiter #(
   parameter int STARVE_LIMIT = 3,
   parameter int NREG         = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [2:0]      a_reg,
   input  logic [15:0]     a_data,
   input  logic            a_qen,
   input  logic [1:0]      a_q,
   input  logic            m_valid,
   output logic            m_ready,
   input  logic [2:0]      m_reg,
   input  logic [15:0]     m_data,
   input  logic            m_qen,
   input  logic [1:0]      m_q,
   input  logic            iss_valid,
   input  logic [2:0]      iss_reg,
   output logic            iss_ready,
   input  logic [2:0]      chk_reg0,
   input  logic [2:0]      chk_reg1,
   output logic            hazard,
   output logic [NREG-1:0] busy,
`ifdef WB_CONFLICT_CNT_EN
   output logic [15:0]     conflict_cnt,
`endif
   output logic            rf_write,
   output logic [3:0]      rf_writeReg,
   output logic [15:0]     rf_writeData,
   output logic            rf_set_quarter,
   output logic [1:0]      rf_quarter
);

   localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0]   starveCnt_r;
   logic [1:0]      pendCnt_r [NREG];
   logic            starveAtLimit_s;
   logic            aGrant_s;
   logic            mGrant_s;
   logic            issFire_s;
   logic [2:0]      commitReg_s;
   logic [NREG-1:0] incVec_s;
   logic [NREG-1:0] decVec_s;

   // Memory has priority unless the ALU has been passed over STARVE_LIMIT times in a row.
   assign starveAtLimit_s = (starveCnt_r == SW'(STARVE_LIMIT));
   assign a_ready         = ~reset & (~m_valid | starveAtLimit_s);
   assign m_ready         = ~reset & ~(a_valid & starveAtLimit_s);
   assign aGrant_s        = a_valid & a_ready;
   assign mGrant_s        = m_valid & m_ready;

   assign commitReg_s = rf_writeReg[2:0];
   assign iss_ready   = ~reset & ((pendCnt_r[iss_reg] != 2'd3) | (rf_write & (commitReg_s == iss_reg)));
   assign issFire_s   = iss_valid & iss_ready;
   assign hazard      = ~reset & (busy[chk_reg0] | busy[chk_reg1]);

   // Per-register scoreboard increment/decrement requests and the busy bitmap.
   always_comb begin
      incVec_s = '0;
      decVec_s = '0;
      busy     = '0;
      for (int i = 0; i < NREG; i++) begin
         incVec_s[i] = issFire_s & (iss_reg == 3'(i));
         decVec_s[i] = rf_write & (commitReg_s == 3'(i));
         busy[i]     = (pendCnt_r[i] != 2'd0);
      end
   end

   // Starvation counter: consecutive memory grants while the ALU is waiting.
   always_ff @(posedge clk) begin
      if (reset) begin
         starveCnt_r <= '0;
      end else if (aGrant_s || !a_valid) begin
         starveCnt_r <= '0;
      end else if (mGrant_s && !starveAtLimit_s) begin
         starveCnt_r <= starveCnt_r + SW'(1);
      end
   end

   // Register the winning write onto the regfile port; fields hold when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_write       <= 1'b0;
         rf_writeReg    <= 4'h0;
         rf_writeData   <= 16'h0000;
         rf_set_quarter <= 1'b0;
         rf_quarter     <= 2'd0;
      end else begin
         rf_write <= aGrant_s | mGrant_s;
         if (aGrant_s) begin
            rf_writeReg    <= {1'b0, a_reg};
            rf_writeData   <= a_data;
            rf_set_quarter <= a_qen;
            rf_quarter     <= a_q;
         end else if (mGrant_s) begin
            rf_writeReg    <= {1'b0, m_reg};
            rf_writeData   <= m_data;
            rf_set_quarter <= m_qen;
            rf_quarter     <= m_q;
         end
      end
   end

   // Pending-write counters; an issue and a commit to the same register cancel out.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (reset) begin
            pendCnt_r[i] <= 2'd0;
         end else if (incVec_s[i] && !decVec_s[i]) begin
            pendCnt_r[i] <= pendCnt_r[i] + 2'd1;
         end else if (decVec_s[i] && !incVec_s[i] && (pendCnt_r[i] != 2'd0)) begin
            pendCnt_r[i] <= pendCnt_r[i] - 2'd1;
         end
      end
   end

`ifdef WB_CONFLICT_CNT_EN
   // Cycles in which both requesters contend, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict_cnt <= 16'h0000;
      end else if (a_valid && m_valid && (conflict_cnt != 16'hFFFF)) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end
   end
`endif

   regfile_wb_arbiter_chk #(.NREG(NREG)) u_chk (
      .clk       (clk),
      .reset     (reset),
      .rfWrite   (rf_write),
      .commitReg (commitReg_s),
      .busyVec   (busy)
   );

endmodule

// Checks that every commit retires a write that the scoreboard is tracking.
module regfile_wb_arbiter_chk #(
   parameter int NREG = 8
) (
   input logic            clk,
   input logic            reset,
   input logic            rfWrite,
   input logic [2:0]      commitReg,
   input logic [NREG-1:0] busyVec
);

   commitHasPending_a : assert property (@(posedge clk) disable iff (reset) rfWrite |-> busyVec[commitReg])
      else $error("scoreboard commit to register %0d with no pending write", commitReg);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a behavioural scoreboard/arbiter model.
module tb_regfile_wb_arbiter;

   localparam int LIMIT = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, a_valid, a_qen, m_valid, m_qen, iss_valid;
   logic [2:0]  a_reg, m_reg, iss_reg, chk_reg0, chk_reg1;
   logic [15:0] a_data, m_data;
   logic [1:0]  a_q, m_q;
   logic        a_ready, m_ready, iss_ready, hazard, rf_write, rf_set_quarter;
   logic [7:0]  busy;
   logic [3:0]  rf_writeReg;
   logic [15:0] rf_writeData;
   logic [1:0]  rf_quarter;
`ifdef WB_CONFLICT_CNT_EN
   logic [15:0] conflict_cnt;
`endif

   regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .NREG(8)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data), .a_qen(a_qen), .a_q(a_q),
      .m_valid(m_valid), .m_ready(m_ready), .m_reg(m_reg), .m_data(m_data), .m_qen(m_qen), .m_q(m_q),
      .iss_valid(iss_valid), .iss_reg(iss_reg), .iss_ready(iss_ready),
      .chk_reg0(chk_reg0), .chk_reg1(chk_reg1), .hazard(hazard), .busy(busy),
`ifdef WB_CONFLICT_CNT_EN
      .conflict_cnt(conflict_cnt),
`endif
      .rf_write(rf_write), .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
      .rf_set_quarter(rf_set_quarter), .rf_quarter(rf_quarter)
   );

   int checks = 0;
   int failures = 0;

   // Reference model state
   int pend [8];
   int credit [8];
   int starve, eReg, eData, eQ, conflicts;
   bit eWrite, eQen;
   bit lastAGrant, lastMGrant;
   bit obsARdy, obsMRdy, obsIssRdy;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic compareAll();
      bit aRdy, mRdy, issRdy, haz;
      logic [7:0] expBusy;
      aRdy   = !reset && !(m_valid && starve < LIMIT);
      mRdy   = !reset && !(a_valid && starve == LIMIT);
      issRdy = !reset && (pend[iss_reg] < 3 || (eWrite && eReg == int'(iss_reg)));
      haz    = !reset && (pend[chk_reg0] > 0 || pend[chk_reg1] > 0);
      for (int i = 0; i < 8; i++) expBusy[i] = (pend[i] != 0);
      checkVal("a_ready", a_ready, aRdy);
      checkVal("m_ready", m_ready, mRdy);
      checkVal("iss_ready", iss_ready, issRdy);
      checkVal("hazard", hazard, haz);
      checkVal("busy", busy, expBusy);
      checkVal("rf_write", rf_write, eWrite);
      checkVal("rf_writeReg", rf_writeReg, eReg);
      checkVal("rf_writeData", rf_writeData, eData);
      checkVal("rf_set_quarter", rf_set_quarter, eQen);
      checkVal("rf_quarter", rf_quarter, eQ);
`ifdef WB_CONFLICT_CNT_EN
      checkVal("conflict_cnt", conflict_cnt, conflicts);
`endif
   endtask

   task automatic advanceModel();
      bit aG, mG, issF, issRdy;
      if (reset) begin
         for (int i = 0; i < 8; i++) pend[i] = 0;
         starve = 0; eWrite = 0; eReg = 0; eData = 0; eQen = 0; eQ = 0; conflicts = 0;
         lastAGrant = 0; lastMGrant = 0;
      end else begin
         mG     = m_valid && !(a_valid && starve == LIMIT);
         aG     = a_valid && !mG;
         issRdy = pend[iss_reg] < 3 || (eWrite && eReg == int'(iss_reg));
         issF   = iss_valid && issRdy;
         if (issF && eWrite && eReg == int'(iss_reg)) begin
            // issue and commit to the same register cancel
         end else begin
            if (eWrite && pend[eReg] > 0) pend[eReg]--;
            if (issF) pend[iss_reg]++;
         end
         if (issF) credit[iss_reg]++;
         if (mG && a_valid) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
         else starve = 0;
         if (a_valid && m_valid && conflicts < 65535) conflicts++;
         eWrite = aG || mG;
         if (aG) begin
            eReg = a_reg; eData = a_data; eQen = a_qen; eQ = a_q;
         end else if (mG) begin
            eReg = m_reg; eData = m_data; eQen = m_qen; eQ = m_q;
         end
         lastAGrant = aG; lastMGrant = mG;
      end
   endtask

   task automatic step();
      @(negedge clk);
      obsARdy = a_ready; obsMRdy = m_ready; obsIssRdy = iss_ready;
      compareAll();
      advanceModel();
      @(posedge clk);
      #1;
   endtask

   task automatic issueReg(input logic [2:0] r);
      iss_valid = 1'b1; iss_reg = r;
      step();
      iss_valid = 1'b0;
   endtask

   function automatic int pickReg();
      int s;
      s = $urandom % 8;
      for (int k = 0; k < 8; k++) if (credit[(s + k) % 8] > 0) return (s + k) % 8;
      return -1;
   endfunction

   int memRegs [7] = '{1, 1, 4, 4, 6, 6, 5};
   logic [7:0] pat;
   int ai, mi, r;

   initial begin
      reset = 1'b1; a_valid = 0; a_reg = 0; a_data = 0; a_qen = 0; a_q = 0;
      m_valid = 0; m_reg = 0; m_data = 0; m_qen = 0; m_q = 0;
      iss_valid = 0; iss_reg = 0; chk_reg0 = 0; chk_reg1 = 0;
      for (int i = 0; i < 8; i++) credit[i] = 0;
      advanceModel();
      repeat (2) @(posedge clk);
      #1;
      step(); step();
      reset = 1'b0;

      // ALU write alone
      issueReg(3'd2);
      a_valid = 1; a_reg = 3'd2; a_data = 16'h1234;
      step();
      checkVal("t1_a_ready", obsARdy, 1);
      a_valid = 0;
      checkVal("t1_rf_write", rf_write, 1);
      checkVal("t1_writeReg", rf_writeReg, 4'h2);
      checkVal("t1_writeData", rf_writeData, 16'h1234);
      step();

      // Starvation-bounded priority with both requesters held
      issueReg(3'd0); issueReg(3'd0);
      for (int k = 0; k < 7; k++) issueReg(3'(memRegs[k]));
      ai = 0; mi = 0; pat = 8'h00;
      a_valid = 1; a_reg = 3'd0; a_data = 16'hA0A0;
      m_valid = 1; m_reg = 3'(memRegs[0]); m_data = 16'h5A5A;
      for (int c = 0; c < 8; c++) begin
         step();
         if (a_valid && obsARdy) begin
            pat[c] = 1'b1; ai++;
            if (ai >= 2) a_valid = 0;
         end
         if (m_valid && obsMRdy) begin
            mi++;
            if (mi < 7) m_reg = 3'(memRegs[mi]); else m_valid = 0;
         end
      end
      checkVal("t2_grant_order", pat, 8'h88);
      a_valid = 0;
      for (int k = 0; k < 4 && m_valid; k++) begin
         step();
         if (lastMGrant) m_valid = 0;
      end
      step(); step();

      // Memory quarter write
      issueReg(3'd5);
      m_valid = 1; m_reg = 3'd5; m_data = 16'h000A; m_qen = 1; m_q = 2'd2;
      step();
      m_valid = 0; m_qen = 0;
      checkVal("t3_set_quarter", rf_set_quarter, 1);
      checkVal("t3_quarter", rf_quarter, 2);
      checkVal("t3_writeReg", rf_writeReg, 4'h5);
      step();

      // Saturating pending counter and hazard
      chk_reg0 = 3'd3; chk_reg1 = 3'd3;
      iss_valid = 1; iss_reg = 3'd3;
      for (int k = 0; k < 4; k++) step();
      iss_valid = 0;
      checkVal("t4_iss_ready_4th", obsIssRdy, 0);
      checkVal("t4_busy3", busy[3], 1);
      checkVal("t4_hazard", hazard, 1);
      a_valid = 1; a_reg = 3'd3; a_data = 16'hBEEF;
      repeat (3) step();
      a_valid = 0;
      checkVal("t4_hazard_during_last_write", hazard, 1);
      step();
      checkVal("t4_busy3_clear", busy[3], 0);
      checkVal("t4_hazard_clear", hazard, 0);

      // Issue and commit to the same register in one cycle
      issueReg(3'd1);
      a_valid = 1; a_reg = 3'd1; a_data = 16'h0101;
      step();
      a_valid = 0;
      issueReg(3'd1);
      checkVal("t5_busy1", busy[1], 1);
      step();

      // Randomized traffic
      for (int i = 0; i < 8; i++) credit[i] = pend[i];
      lastAGrant = 0; lastMGrant = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!a_valid || lastAGrant) begin
            a_valid = 0;
            if ($urandom % 4 != 0) begin
               r = pickReg();
               if (r >= 0) begin
                  credit[r]--; a_valid = 1; a_reg = 3'(r);
                  a_data = 16'($urandom); a_qen = 1'($urandom); a_q = 2'($urandom);
               end
            end
         end
         if (!m_valid || lastMGrant) begin
            m_valid = 0;
            if ($urandom % 4 != 0) begin
               r = pickReg();
               if (r >= 0) begin
                  credit[r]--; m_valid = 1; m_reg = 3'(r);
                  m_data = 16'($urandom); m_qen = 1'($urandom); m_q = 2'($urandom);
               end
            end
         end
         iss_valid = 1'($urandom); iss_reg = 3'($urandom);
         chk_reg0 = 3'($urandom); chk_reg1 = 3'($urandom);
         step();
      end
      iss_valid = 0;
      for (int k = 0; k < 40 && (a_valid || m_valid); k++) begin
         if (lastAGrant) a_valid = 0;
         if (lastMGrant) m_valid = 0;
         if (a_valid || m_valid) step();
      end
      checkVal("drain_idle", {a_valid, m_valid}, 2'b00);
      step();

      // Reset in the cycle after a grant, mid-starvation
      reset = 1; step(); reset = 0;
      issueReg(3'd0); issueReg(3'd1); issueReg(3'd1);
      a_valid = 1; a_reg = 3'd0; m_valid = 1; m_reg = 3'd1;
      step(); step();
      a_valid = 0; m_valid = 0; reset = 1;
      step();
      reset = 0;
      checkVal("t6_rf_write", rf_write, 0);
      checkVal("t6_busy", busy, 8'h00);
`ifdef WB_CONFLICT_CNT_EN
      checkVal("t6_conflict_cnt", conflict_cnt, 16'h0000);
`endif
      step();
      issueReg(3'd1); issueReg(3'd1); issueReg(3'd1); issueReg(3'd0);
      a_valid = 1; a_reg = 3'd0; m_valid = 1; m_reg = 3'd1;
      pat = 8'h00; mi = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (a_valid && obsARdy) begin
            pat[c] = 1'b1; a_valid = 0;
         end
         if (m_valid && obsMRdy) begin
            mi++;
            if (mi >= 3) m_valid = 0;
         end
      end
      a_valid = 0; m_valid = 0;
      checkVal("t6_starve_cleared", pat, 8'h08);
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Controller that shares the register file's single write port between two writeback requesters: the ALU path and the memory-load path. It arbitrates with a starvation-bounded fixed priority and registers the winning write onto the regfile write-port signals. It also keeps a per-register pending-write scoreboard so the issue/decode stage can stall on read-after-write hazards. It sits between the execute/memory stages and the regfile.

Parameters:
STARVE_LIMIT, 3, maximum consecutive memory grants while the ALU waits before the ALU is forced through
NREG, 8, architectural registers tracked: reg0-reg3, adr, math, cmp, cnt

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
a_valid  in  1  ALU writeback request
a_ready  out  1  ALU request accepted this cycle
a_reg  in  3  ALU destination register
a_data  in  16  ALU write data
a_qen  in  1  ALU quarter-write (nibble) enable
a_q  in  2  ALU nibble select
m_valid  in  1  memory-load writeback request
m_ready  out  1  memory request accepted this cycle
m_reg  in  3  memory destination register
m_data  in  16  memory write data
m_qen  in  1  memory quarter-write enable
m_q  in  2  memory nibble select
iss_valid  in  1  issue stage marks a destination as pending
iss_reg  in  3  destination being issued
iss_ready  out  1  issue accepted (target counter not saturated)
chk_reg0  in  3  decode read register 0
chk_reg1  in  3  decode read register 1
hazard  out  1  either chk register has a pending write
busy  out  8  per-register pending bitmap
rf_write  out  1  to regfile write
rf_writeReg  out  4  to regfile writeReg, upper bit 0
rf_writeData  out  16  to regfile writeData
rf_set_quarter  out  1  to regfile set_quarter
rf_quarter  out  2  nibble select driven to regfile readReg1 during the write

Behaviour:
- Reset (synchronous, active high) clears all rf_* outputs, busy, every pending counter, and the starvation counter. a_ready, m_ready, iss_ready and hazard are 0 during reset.
- Handshake: a transfer occurs when valid && ready. A requester holds reg, data, qen and q stable while valid && !ready. ready is combinational from the valids and the starvation counter and never depends on its own valid.
- Arbitration, one grant per cycle:
  - Only one valid: that requester is granted.
  - Both valid: memory wins unless starve_cnt == STARVE_LIMIT, in which case the ALU wins.
- starve_cnt:
  - Increments on each memory grant while a_valid is high.
  - Clears on any ALU grant, or when a_valid is low.
  - Saturates at STARVE_LIMIT.
- Output latency is 1 cycle. rf_write is 1 in the cycle after a grant, with the granted reg/data/qen/q. Otherwise rf_write is 0, and the other rf_* outputs hold their last value.
- Scoreboard: each register has a 2-bit pending counter.
  - Increments on an iss_valid && iss_ready transfer.
  - Decrements when rf_write commits that register.
  - Simultaneous increment and decrement of the same register leaves it unchanged.
  - iss_ready = 0 when the target counter is 3, unless a commit to that register occurs in the same cycle.
  - A decrement at 0 is illegal. The counter stays 0 and a simulation assertion fires.
- busy[i] = (counter i != 0).
- hazard = busy[chk_reg0] | busy[chk_reg1], combinational. Hazard does not clear early for a register being written in the same cycle; consumers see the clear one cycle after rf_write.
- Quarter writes count as full commits for the scoreboard.
- Reset mid-operation discards the in-flight registered write (rf_write forced to 0) and all pending state.

Optional Feature:
WB_CONFLICT_CNT_EN
- Defined: adds output conflict_cnt (16 bits), which counts cycles with a_valid && m_valid. It saturates at 16'hFFFF and clears on reset.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then a_valid alone with reg 2, data 16'h1234 -> a_ready=1 that cycle; next cycle rf_write=1, rf_writeReg=4'h2, rf_writeData=16'h1234.
- a_valid and m_valid held continuously, STARVE_LIMIT=3 -> grant order M,M,M,A,M,M,M,A; a_ready high on every 4th cycle.
- m_valid with m_qen=1, m_q=2, m_data=16'h000A, reg 5 -> rf_set_quarter=1, rf_quarter=2, rf_writeReg=4'h5 one cycle later.
- Issue reg 3 four times with no commits -> busy[3]=1; iss_ready=0 on the 4th attempt; chk_reg0=3 gives hazard=1. Three commits to reg 3 -> busy[3]=0 and hazard=0 one cycle after the last rf_write.
- Issue reg 1 in the same cycle its write commits, with counter at 1 -> counter stays 1 and busy[1] stays 1.
- Assert reset in the cycle after a grant -> rf_write=0 next cycle; busy=0; starve_cnt=0; with the macro defined, conflict_cnt=0.
